// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM on one shared prescaled R-bit counter, duty updates shadowed to the period boundary.
// Optional CENTER_ALIGNED_EN: up/down counter with the boundary at the bottom (cnt reaching 0 while counting down).
module pwm_multi #(
    parameter int R       = 8,
    parameter int CH      = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [CH*R-1:0]    duty,
    input  logic               duty_load,
    output logic [CH-1:0]      pwm_out,
    output logic               period_tick,
    output logic               load_pending
);
    localparam logic [R-1:0] CNT_MAX = '1;
    localparam logic [R-1:0] CNT_ONE = {{(R-1){1'b0}}, 1'b1};
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [R-1:0]       cnt_q, cnt_d;
    logic [R-1:0]       act_q [CH];
    logic [R-1:0]       act_d [CH];
    logic [R-1:0]       shadow_q [CH];
    logic [R-1:0]       shadow_d [CH];
    logic [CH-1:0]      pwm_q, pwm_d;
    logic               tick_q, tick_d, pend_q, pend_d;
    logic               tick, boundary, apply;
    assign tick         = presc_q >= prescale;
    assign presc_d      = tick ? '0 : presc_q + 1'b1;
    assign apply        = !enable || boundary;
    assign pwm_out      = pwm_q;
    assign period_tick  = tick_q;
    assign load_pending = pend_q;
`ifdef CENTER_ALIGNED_EN
    logic down_q, down_d;
    // Triangle count: turn around at the top, flip back to up on reaching 0; boundary is the step down to 0.
    always_comb begin
        cnt_d    = cnt_q;
        down_d   = down_q;
        boundary = tick && down_q && cnt_q == CNT_ONE;
        if (tick && down_q) begin
            cnt_d  = cnt_q - 1'b1;
            down_d = cnt_q != CNT_ONE;
        end else if (tick) begin
            cnt_d  = cnt_q == CNT_MAX ? CNT_MAX - 1'b1 : cnt_q + 1'b1;
            down_d = cnt_q == CNT_MAX;
        end
    end
    // Direction register; disabled or reset always restarts counting up.
    always_ff @(posedge clk) begin
        down_q <= !reset && enable && down_d;
    end
`else
    // Edge-aligned up-counter; boundary is the wrap from the top back to 0.
    always_comb begin
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        boundary = tick && cnt_q == CNT_MAX;
    end
`endif
    // Duty shadowing: a load coinciding with an apply point goes straight to the active set.
    always_comb begin
        pend_d = apply ? 1'b0 : pend_q || duty_load;
        tick_d = enable && boundary;
        for (int i = 0; i < CH; i++) begin
            shadow_d[i] = duty_load ? duty[i*R +: R] : shadow_q[i];
            act_d[i]    = !apply ? act_q[i] : duty_load ? duty[i*R +: R] : pend_q ? shadow_q[i] : act_q[i];
            pwm_d[i]    = enable && cnt_q < act_q[i];
        end
    end
    // State update; disabled holds prescaler and counter at 0 while still taking loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                act_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            presc_q <= enable ? presc_d : '0;
            cnt_q   <= enable ? cnt_d : '0;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            for (int i = 0; i < CH; i++) begin
                act_q[i]    <= act_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: random and directed stimulus against a period-position model of pwm_multi.
module tb_pwm_multi;
    localparam int R = 8, CH = 4, PW = 8;
`ifdef CENTER_ALIGNED_EN
    localparam int PER = 2 * (2**R - 1);
`else
    localparam int PER = 2**R;
`endif
    logic clk = 0;
    logic reset, enable, duty_load;
    logic [PW-1:0] prescale;
    logic [CH*R-1:0] duty;
    logic [CH-1:0] pwm_out;
    logic period_tick, load_pending;
    int passed = 0, total = 0;
    int m_presc, m_pos, m_pend, t;
    int m_act[CH], m_sh[CH], h[CH];
    logic [CH-1:0] e_pwm;
    logic e_tick;

    always #5 clk = ~clk;

    pwm_multi #(.R(R), .CH(CH), .PRESC_W(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .prescale(prescale), .duty(duty),
        .duty_load(duty_load), .pwm_out(pwm_out), .period_tick(period_tick), .load_pending(load_pending)
    );

    // counter value at a position within the period (triangle when center-aligned)
    function automatic int cnt_of(int p);
        return p < 2**R ? p : PER - p;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // advance the model by one clk using the inputs about to be sampled
    task automatic model();
        int c;
        bit tk, bnd;
        c = cnt_of(m_pos);
        if (reset) begin
            m_presc = 0; m_pos = 0; m_pend = 0; e_pwm = '0; e_tick = 0;
            for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_sh[i] = 0; end
        end else if (!enable) begin
            m_presc = 0; m_pos = 0; e_pwm = '0; e_tick = 0;
            if (duty_load) for (int i = 0; i < CH; i++) begin m_act[i] = int'(duty[i*R +: R]); m_sh[i] = m_act[i]; end
            else if (m_pend != 0) for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
            m_pend = 0;
        end else begin
            for (int i = 0; i < CH; i++) e_pwm[i] = c < m_act[i];
            tk = m_presc >= int'(prescale);
            bnd = tk && m_pos == PER - 1;
            m_presc = tk ? 0 : m_presc + 1;
            if (tk) m_pos = (m_pos + 1) % PER;
            e_tick = bnd;
            if (duty_load) for (int i = 0; i < CH; i++) m_sh[i] = int'(duty[i*R +: R]);
            if (bnd && (duty_load || m_pend != 0)) begin
                for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
                m_pend = 0;
            end else if (duty_load) m_pend = 1;
        end
    endtask

    // one clk: model, edge, compare on the falling edge, drop strobes
    task automatic step();
        model();
        @(posedge clk);
        @(negedge clk);
        check("pwm_out", int'(pwm_out), int'(e_pwm));
        check("period_tick", int'(period_tick), int'(e_tick));
        check("load_pending", int'(load_pending), m_pend);
        duty_load = 0;
        reset = 0;
    endtask

    task automatic wait_tick(int lim);
        int k = 0;
        while (period_tick !== 1'b1 && k < lim) begin step(); k++; end
        check("tick_seen", int'(period_tick), 1);
    endtask

    task automatic measure(int n);
        for (int i = 0; i < CH; i++) h[i] = 0;
        t = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < CH; i++) h[i] += int'(pwm_out[i]);
            t += int'(period_tick);
        end
    endtask

    task automatic seek_cnt(int v);
        int k = 0;
        while (cnt_of(m_pos) != v && k < 2 * PER) begin step(); k++; end
    endtask

    initial begin
        int lo[CH];
        int k;
        reset = 1; enable = 0; prescale = 0; duty = '0; duty_load = 0;
        m_presc = 0; m_pos = 0; m_pend = 0;
        for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_sh[i] = 0; end
        step();
        reset = 1;
        step();
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_pend", int'(load_pending), 0);
        // four channels, prescale 0
        enable = 1; duty = {8'd192, 8'd128, 8'd64, 8'd0}; duty_load = 1;
        step();
        check("pend_after_load", int'(load_pending), 1);
        wait_tick(PER + 10);
        check("pend_applied", int'(load_pending), 0);
        measure(PER);
`ifdef CENTER_ALIGNED_EN
        lo = '{0, 127, 255, 383};
`else
        lo = '{0, 64, 128, 192};
`endif
        for (int i = 0; i < CH; i++) check($sformatf("high_ch%0d", i), h[i], lo[i]);
        check("ticks_per_period", t, 1);
        // prescale 9, ch0 = 128
        duty = {24'd0, 8'd128}; duty_load = 1; prescale = 9;
        step();
        wait_tick(PER * 10 + 20);
        measure(PER * 10);
`ifdef CENTER_ALIGNED_EN
        check("presc_high_ch0", h[0], 2550);
`else
        check("presc_high_ch0", h[0], 1280);
`endif
        check("presc_ticks", t, 1);
        // mid-period load 64 -> 200 at cnt 100
        prescale = 0; duty = {24'd0, 8'd64}; duty_load = 1;
        step();
        wait_tick(PER * 10 + 20);
        seek_cnt(100);
        duty = {24'd0, 8'd200}; duty_load = 1;
        step();
        check("mid_load_pend", int'(load_pending), 1);
        wait_tick(PER + 10);
        check("mid_load_applied", int'(load_pending), 0);
        measure(PER);
`ifdef CENTER_ALIGNED_EN
        check("mid_load_high", h[0], 399);
`else
        check("mid_load_high", h[0], 200);
`endif
        // load exactly on the boundary tick
        k = 0;
        while (!(m_pos == PER - 1 && m_presc >= int'(prescale)) && k < 2 * PER) begin step(); k++; end
        duty = {24'd0, 8'd33}; duty_load = 1;
        step();
        check("wrap_load_no_pend", int'(load_pending), 0);
        check("wrap_load_tick", int'(period_tick), 1);
        // two loads in one period, last wins
        repeat (10) step();
        duty = {24'd0, 8'd10}; duty_load = 1;
        repeat (10) step();
        duty = {24'd0, 8'd77}; duty_load = 1;
        step();
        wait_tick(PER + 10);
        measure(PER);
`ifdef CENTER_ALIGNED_EN
        check("last_load_high", h[0], 153);
`else
        check("last_load_high", h[0], 77);
`endif
        // reset at cnt 150
        seek_cnt(150);
        reset = 1;
        step();
        check("midreset_pwm", int'(pwm_out), 0);
        check("midreset_tick", int'(period_tick), 0);
        measure(PER);
        for (int i = 0; i < CH; i++) check($sformatf("after_reset_ch%0d", i), h[i], 0);
        // enable drop mid-period, load while disabled
        duty = {4{8'd100}}; duty_load = 1;
        step();
        wait_tick(PER + 10);
        repeat (50) step();
        enable = 0;
        step();
        check("disable_pwm", int'(pwm_out), 0);
        check("disable_tick", int'(period_tick), 0);
        duty = {8'd100, 8'd100, 8'd50, 8'd100}; duty_load = 1;
        repeat (5) step();
        enable = 1;
        measure(PER);
`ifdef CENTER_ALIGNED_EN
        check("reenable_ch0", h[0], 199);
        check("reenable_ch1", h[1], 99);
`else
        check("reenable_ch0", h[0], 100);
        check("reenable_ch1", h[1], 50);
`endif
        // random traffic
        repeat (6000) begin
            if ($urandom_range(0, 599) == 0) reset = 1;
            if ($urandom_range(0, 399) == 0) enable = !enable;
            if ($urandom_range(0, 299) == 0) prescale = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin duty = 32'($urandom()); duty_load = 1; end
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator that replaces the single-channel pwm block. CH channels share one R-bit period counter, which advances through a programmable clock prescaler. Each channel has its own duty value held in a shadow register. New duty values take effect only at the period boundary, so no glitched periods appear on the outputs. The block sits between the control/register logic and the board outputs (LEDs, motor/servo pins).

Parameters:
R, 8, counter/duty resolution in bits; period is 2^R counter steps
CH, 4, number of PWM channels
PRESC_W, 8, prescaler width in bits

Ports:
clk  input  1  system clock (100 MHz on board)
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run; 0 = hold counter and prescaler at 0 and force outputs low
prescale  input  PRESC_W  counter advances once every prescale+1 clk cycles
duty  input  CH*R  packed duty values; channel i uses bits [i*R +: R]
duty_load  input  1  one-cycle strobe that captures all of duty into the shadow registers
pwm_out  output  CH  registered PWM outputs
period_tick  output  1  one-clk pulse at each period boundary
load_pending  output  1  1 = shadow values captured but not yet applied

Behaviour:
- Reset (clk edge with reset=1) clears the following, all to 0:
  - prescaler count and period counter cnt
  - active duty registers and shadow duty registers
  - pwm_out, period_tick and load_pending
- Reset has priority over all other inputs. Reset mid-period aborts the period immediately. The next period starts from cnt=0 with all duties 0.
- Prescaler:
  - tick=1 when presc_cnt >= prescale; presc_cnt then returns to 0, otherwise it increments.
  - Using >= means lowering prescale mid-count never stalls the prescaler.
  - prescale=0 gives tick every clk.
- Counter:
  - cnt increments on tick and wraps from 2^R-1 to 0 (the boundary event).
  - period_tick is registered: it pulses for one clk, in the cycle after the tick that wraps cnt.
- Output:
  - pwm_out[i] <= enable & (cnt < duty_act[i]), registered, so it lags cnt by one clk.
  - duty=0 gives constant 0.
  - duty=2^R-1 gives high for 2^R-1 of 2^R steps; 100% duty is not representable.
- Duty update:
  - duty_load=1 copies duty into the shadow registers and sets load_pending.
  - At the boundary event, if load_pending=1: duty_act <= shadow and load_pending clears.
  - If duty_load coincides with the boundary event, the incoming duty is written directly to duty_act and load_pending stays 0.
  - Multiple loads within one period: the last one wins.
- enable=0:
  - presc_cnt=0, cnt=0, pwm_out=0, period_tick=0.
  - Shadow loads are still accepted. A pending load is applied on the first clk with enable=0, so the first period after re-enable uses the new values.
  - On the rising edge of enable, counting starts from cnt=0.
- Width rules: comparisons are unsigned R-bit; presc_cnt is PRESC_W bits; no arithmetic overflow is possible beyond the wraps defined above.

Optional Feature:
Macro CENTER_ALIGNED_EN.
- Defined:
  - cnt counts up 0 to 2^R-1, then down to 0, reversing at each end with no repeated values.
  - Period is 2*(2^R-1) ticks.
  - The boundary event (shadow apply, period_tick) happens only at the bottom, when cnt becomes 0 while counting down.
  - Output rule is unchanged (cnt < duty_act), which gives pulses symmetric about the bottom of the period.
  - enable=0 or reset also sets the direction to up.
- Not defined: edge-aligned up-counter only; no direction register is built.

Test Plan:
- R=8, CH=4, prescale=0, enable=1; load duty {192,128,64,0} (ch3..ch0) before the first boundary -> per 256-clk period (2560 ns): ch0 high 0 clks, ch1 high 64, ch2 high 128, ch3 high 192; period_tick every 256 clks.
- Prescale=9, ch0 duty=128 -> period 2560 clks; ch0 high for the first 1280 clks of each period.
- With ch0 at 64, pulse duty_load with ch0=200 at cnt=100 -> remainder of that period still uses 64; load_pending=1 until the wrap; the next period is high for 200 clks.
- duty_load exactly on the wrap tick -> new duty active in the period starting at cnt=0; load_pending never asserts. Two loads in one period -> only the second is applied.
- Assert reset for 1 clk at cnt=150; separately drop enable mid-period -> all outputs 0 next clk; cnt=0; duty_act=0 after reset; after enable returns, counting restarts from 0.
- With CENTER_ALIGNED_EN, prescale=0, duty=64 -> period 510 clks; output high for 127 clks centred on cnt=0; period_tick only at the bottom.
